// File: rtl/arb_pkg.sv
// Shared types for the two-requester arbiter: FSM state and source id.
package arb_pkg;

  // Output register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Identifies which requester supplied a word.
  typedef logic src_id_t;

  localparam src_id_t SRC0 = 1'b0;
  localparam src_id_t SRC1 = 1'b1;

  // Round-robin helper: the requester that was not just served.
  function automatic src_id_t other_src(input src_id_t src);
    return (src == SRC0) ? SRC1 : SRC0;
  endfunction

endpackage

// File: rtl/mux_arbiter_mux2.sv
// Purely combinational 2:1 data mux; sel_i high picks data0_i.
module mux_arbiter_mux2 #(
  parameter int SIZE = 32
) (
  input  logic            sel_i,
  input  logic [SIZE-1:0] data0_i,
  input  logic [SIZE-1:0] data1_i,
  output logic [SIZE-1:0] data_o
);

  // Select between the two requester words.
  always_comb begin
    data_o = sel_i ? data0_i : data1_i;
  end

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter feeding a single registered output slot
// with valid/ready handshakes on both sides and full back-to-back throughput.
module mux_arbiter
  import arb_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req0_valid_i,
  input  logic [SIZE-1:0] req0_data_i,
  output logic            req0_ready_o,
  input  logic            req1_valid_i,
  input  logic [SIZE-1:0] req1_data_i,
  output logic            req1_ready_o,
  output logic            out_valid_o,
  output logic [SIZE-1:0] out_data_o,
  output logic            out_src_o,
  input  logic            out_ready_i
);

  state_e          state_q, state_d;
  src_id_t         prio_q, prio_d;
  src_id_t         src_q, src_d;
  logic [SIZE-1:0] data_q, data_d;

  logic            slot_free;
  logic            grant0;
  logic            grant1;
  logic            grant;
  logic [SIZE-1:0] mux_data;

  assign out_valid_o = (state_q == FULL);
  assign out_data_o  = data_q;
  assign out_src_o   = src_q;

  // Arbitration: the slot is free when empty or draining this cycle; a lone
  // valid requester wins, a tie goes to prio_q. Readies depend only on valids,
  // state, out_ready_i and prio_q, and are held low while reset is asserted.
  always_comb begin
    slot_free = (state_q == EMPTY) || (out_valid_o && out_ready_i);
    grant0    = rst_ni && slot_free && req0_valid_i &&
                (!req1_valid_i || (prio_q == SRC0));
    grant1    = rst_ni && slot_free && req1_valid_i &&
                (!req0_valid_i || (prio_q == SRC1));
    grant     = grant0 || grant1;
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // Data selection: sel high routes requester 0.
  mux_arbiter_mux2 #(
    .SIZE (SIZE)
  ) u_mux2 (
    .sel_i   (grant0),
    .data0_i (req0_data_i),
    .data1_i (req1_data_i),
    .data_o  (mux_data)
  );

  // Next-state logic for slot occupancy, priority pointer and output word.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    src_d   = src_q;
    data_d  = data_q;

    case (state_q)
      EMPTY: begin
        if (grant) state_d = FULL;
      end
      FULL: begin
        // Drain without a replacement empties the slot; drain with a grant
        // reloads it in the same edge.
        if (out_ready_i && !grant) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    if (grant) begin
      src_d  = grant0 ? SRC0 : SRC1;
      data_d = mux_data;
      prio_d = other_src(src_d);
    end
  end

  // Register update; reset drops any held word and favours requester 0.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values. The data register is reset too, because a cleared
  // output word is part of the visible reset state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      prio_q  <= SRC0;
      src_q   <= SRC0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      src_q   <= src_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed vector table, async reset
// sequence, and a randomized scoreboard run.
module tb_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_src;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  mux_arbiter #(.SIZE(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req0_valid_i (req0_valid),
    .req0_data_i  (req0_data),
    .req0_ready_o (req0_ready),
    .req1_valid_i (req1_valid),
    .req1_data_i  (req1_data),
    .req1_ready_o (req1_ready),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_src_o    (out_src),
    .out_ready_i  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
    logic        ordy;
    logic        r0;
    logic        r1;
    logic        ov;
    logic [31:0] od;
    logic        osrc;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive at negedge, check readies mid-cycle, check registered outputs after posedge.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    req0_valid = v.v0;
    req0_data  = v.d0;
    req1_valid = v.v1;
    req1_data  = v.d1;
    out_ready  = v.ordy;
    #1;
    check({v.name, "_r0"}, {63'd0, req0_ready}, {63'd0, v.r0});
    check({v.name, "_r1"}, {63'd0, req1_ready}, {63'd0, v.r1});
    @(posedge clk);
    #1;
    check({v.name, "_ov"},   {63'd0, out_valid}, {63'd0, v.ov});
    check({v.name, "_od"},   {32'd0, out_data},  {32'd0, v.od});
    check({v.name, "_osrc"}, {63'd0, out_src},   {63'd0, v.osrc});
  endtask

  logic [32:0] exp_q[$];
  logic        pend0, pend1;
  logic [23:0] cnt0, cnt1;
  logic [32:0] front;

  initial begin
    // Prior state: EMPTY, prio 0, data 0.
    vecs[0]  = '{"idle",      0, 32'h0,         0, 32'h0,         0, 0, 0, 0, 32'h0,         0};
    vecs[1]  = '{"req0_first",1, 32'hAAAA_0001, 0, 32'hDEAD_BEEF, 1, 1, 0, 1, 32'hAAAA_0001, 0};
    vecs[2]  = '{"drain0",    0, 32'h0,         0, 32'h0,         1, 0, 0, 0, 32'hAAAA_0001, 0};
    vecs[3]  = '{"req1_p1",   0, 32'h0,         1, 32'h2222_0001, 0, 0, 1, 1, 32'h2222_0001, 1};
    vecs[4]  = '{"stall_a",   1, 32'h5555_0001, 1, 32'h6666_0001, 0, 0, 0, 1, 32'h2222_0001, 1};
    vecs[5]  = '{"drain1",    0, 32'h0,         0, 32'h0,         1, 0, 0, 0, 32'h2222_0001, 1};
    vecs[6]  = '{"req1_p0",   0, 32'h0,         1, 32'h3333_0001, 0, 0, 1, 1, 32'h3333_0001, 1};
    vecs[7]  = '{"drain2",    0, 32'h0,         0, 32'h0,         1, 0, 0, 0, 32'h3333_0001, 1};
    vecs[8]  = '{"alt0",      1, 32'h1000_0001, 1, 32'h2000_0001, 1, 1, 0, 1, 32'h1000_0001, 0};
    vecs[9]  = '{"alt1",      1, 32'h1000_0002, 1, 32'h2000_0001, 1, 0, 1, 1, 32'h2000_0001, 1};
    vecs[10] = '{"alt2",      1, 32'h1000_0002, 1, 32'h2000_0002, 1, 1, 0, 1, 32'h1000_0002, 0};
    vecs[11] = '{"alt3",      1, 32'h1000_0003, 1, 32'h2000_0002, 1, 0, 1, 1, 32'h2000_0002, 1};
    for (int i = 12; i <= 16; i++)
      vecs[i] = '{"hold5",    1, 32'h1000_0003, 1, 32'h2000_0003, 0, 0, 0, 1, 32'h2000_0002, 1};
    vecs[17] = '{"release",   1, 32'h1000_0003, 1, 32'h2000_0003, 1, 1, 0, 1, 32'h1000_0003, 0};
    vecs[18] = '{"req1_next", 0, 32'h1234_5678, 1, 32'h2000_0003, 1, 0, 1, 1, 32'h2000_0003, 1};
    vecs[19] = '{"hold_end",  0, 32'h0,         0, 32'h0,         0, 0, 0, 1, 32'h2000_0003, 1};

    // Reset with both requesters valid: readies must stay low.
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 32'hFFFF_FFFF;
    req1_valid = 1'b1;
    req1_data  = 32'hEEEE_EEEE;
    out_ready  = 1'b1;
    #12;
    check("rst_ov",   {63'd0, out_valid},  64'd0);
    check("rst_od",   {32'd0, out_data},   64'd0);
    check("rst_osrc", {63'd0, out_src},    64'd0);
    check("rst_r0",   {63'd0, req0_ready}, 64'd0);
    check("rst_r1",   {63'd0, req1_ready}, 64'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b0;
    rst_n      = 1'b1;

    for (int i = 0; i < 20; i++) apply_vec(vecs[i]);

    // Asynchronous reset mid-cycle while FULL: outputs clear with no clock edge.
    @(negedge clk);
    req0_valid = 1'b1;
    req0_data  = 32'h7777_0001;
    req1_valid = 1'b1;
    req1_data  = 32'h8888_0001;
    out_ready  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ov",   {63'd0, out_valid},  64'd0);
    check("arst_od",   {32'd0, out_data},   64'd0);
    check("arst_osrc", {63'd0, out_src},    64'd0);
    check("arst_r0",   {63'd0, req0_ready}, 64'd0);
    check("arst_r1",   {63'd0, req1_ready}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    // prio restored to 0: tie goes to requester 0.
    check("post_rst_r0", {63'd0, req0_ready}, 64'd1);
    check("post_rst_r1", {63'd0, req1_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("post_rst_ov",   {63'd0, out_valid}, 64'd1);
    check("post_rst_od",   {32'd0, out_data},  {32'd0, 32'h7777_0001});
    check("post_rst_osrc", {63'd0, out_src},   64'd0);

    // Randomized run with scoreboard; last cycles stop new words and drain.
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;
    pend0 = 1'b0;
    pend1 = 1'b0;
    cnt0  = 24'd0;
    cnt1  = 24'd0;
    for (int cyc = 0; cyc < 10020; cyc++) begin
      @(negedge clk);
      if (cyc < 10000) begin
        if (!pend0 && ($urandom_range(0, 2) != 0)) begin
          pend0     = 1'b1;
          req0_data = {8'hA0, cnt0};
        end
        if (!pend1 && ($urandom_range(0, 2) != 0)) begin
          pend1     = 1'b1;
          req1_data = {8'hB0, cnt1};
        end
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      req0_valid = pend0;
      req1_valid = pend1;
      #1;
      check("rnd_excl", {63'd0, req0_ready & req1_ready}, 64'd0);
      if (out_valid && !out_ready)
        check("rnd_nofree", {63'd0, req0_ready | req1_ready}, 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected", {31'd0, out_src, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          front = exp_q.pop_front();
          check("rnd_word", {31'd0, out_src, out_data}, {31'd0, front});
        end
      end
      if (req0_valid && req0_ready) begin
        exp_q.push_back({1'b0, req0_data});
        pend0 = 1'b0;
        cnt0  = cnt0 + 24'd1;
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back({1'b1, req1_data});
        pend1 = 1'b0;
        cnt1  = cnt1 + 24'd1;
      end
    end
    check("rnd_left_in_q",  {32'd0, 32'(exp_q.size())}, 64'd0);
    check("rnd_pending",    {62'd0, pend1, pend0},      64'd0);
    check("rnd_final_ov",   {63'd0, out_valid},         64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 32, the data width of both requesters and the output.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req0_valid_i, input, 1, requester 0 has a data word pending.
REQ-005 SHALL have port req0_data_i, input, SIZE, requester 0 data word.
REQ-006 SHALL have port req0_ready_o, output, 1, requester 0 word accepted this cycle when also valid.
REQ-007 SHALL have port req1_valid_i, input, 1, requester 1 has a data word pending.
REQ-008 SHALL have port req1_data_i, input, SIZE, requester 1 data word.
REQ-009 SHALL have port req1_ready_o, output, 1, requester 1 word accepted this cycle when also valid.
REQ-010 SHALL have port out_valid_o, output, 1, output register holds a word.
REQ-011 SHALL have port out_data_o, output, SIZE, registered output word.
REQ-012 SHALL have port out_src_o, output, 1, source of the held word (0 or 1).
REQ-013 SHALL have port out_ready_i, input, 1, consumer accepts the word when out_valid_o is also high.

Function
REQ-014 SHALL implement a two-state FSM: EMPTY (output register empty) and FULL (output register loaded).
REQ-015 SHALL define "slot free" as (state == EMPTY) or (out_valid_o and out_ready_i).
REQ-016 SHALL assert at most one of req0_ready_o and req1_ready_o per cycle; neither when slot not free.
REQ-017 SHALL grant, when the slot is free, the only valid requester if exactly one is valid.
REQ-018 SHALL, when both are valid and the slot is free, grant the requester named by the priority pointer prio_q.
REQ-019 SHALL toggle prio_q to the non-granted requester after every grant (round-robin); unchanged when no grant.
REQ-020 SHALL make ready outputs combinational from the valids, the state, out_ready_i and prio_q, never from ready-dependent paths upstream.
REQ-021 SHALL load the granted data word and its source id into the output register on the grant edge; latency 1 cycle from grant to out_valid_o.
REQ-022 SHALL transition EMPTY->FULL on a grant; FULL->EMPTY on drain with no grant; FULL->FULL on drain with simultaneous grant (back-to-back, full throughput).
REQ-023 SHALL hold out_data_o, out_src_o and out_valid_o stable while out_valid_o is high and out_ready_i is low.
REQ-024 SHALL ignore requester data when its valid is low; out_data_o in EMPTY SHALL retain its last value.
REQ-025 SHALL sustain, with both requesters continuously valid and out_ready_i high, strict alternation 0,1,0,1... (no starvation).

Reset
REQ-026 SHALL, on rst_ni low, asynchronously force state EMPTY, out_valid_o 0, out_data_o 0, out_src_o 0, prio_q 0 (requester 0 favoured first).
REQ-027 SHALL drop a word held mid-transfer when reset asserts; ready outputs SHALL be 0 while rst_ni is low.
REQ-028 SHALL resume arbitration on the first rising clk_i edge after rst_ni deasserts.

Structure
REQ-029 SHALL place the FSM state enum (EMPTY, FULL) and the source-id typedef (1 bit) in shared package arb_pkg.
REQ-030 SHALL instantiate the team's 2:1 mux sub-module (width SIZE) for data selection, driving its sel_i with 1 to select req0_data_i (data0_i), 0 to select req1_data_i.
REQ-031 SHALL keep all arbitration and handshake logic in mux_arbiter; the mux sub-module stays purely combinational.

Verification
REQ-032 SHALL cover: reset, then req0 valid with 0xAAAA_0001 and out_ready_i=1 -> req0_ready_o=1 same cycle; next cycle out_valid_o=1, out_data_o=0xAAAA_0001, out_src_o=0.
REQ-033 SHALL cover: both valid every cycle (0x1000_000n, 0x2000_000n), out_ready_i=1 -> outputs alternate src 0,1,0,1 with one word per cycle, first from src 0.
REQ-034 SHALL cover: FULL with out_ready_i=0 for 5 cycles, both valid -> both ready low, output word unchanged; on out_ready_i=1 -> drain and new grant in same cycle.
REQ-035 SHALL cover: only req1 valid while prio_q=0 -> req1 granted immediately; prio_q becomes 0.
REQ-036 SHALL cover: rst_ni asserted asynchronously mid-cycle while FULL -> out_valid_o=0, out_data_o=0 immediately without a clock edge.
REQ-037 SHALL cover: random valid/ready stimulus for 10000 cycles -> scoreboard sees every accepted word exactly once, in order per source, no grant while slot not free.
